mem_responder: RTL and testbench

- Memory-side responder for the multicycle control unit's memory request interface. Services instruction fetches, loads and stores issued by the control FSM.
- Each request is served from an internal word-addressed RAM with programmable wait states. The block applies byte-lane selection on stores, and alignment plus sign/zero extension on loads.
- Returns a single-cycle response pulse, which the control unit uses to advance out of its fetch/LD_MEM/S_MEM states.

---
 rtl/mem_responder.sv | 218 +++++++++++++++++++++
 tb/tb_mem_responder.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Memory-side responder for the multicycle control unit: word RAM with programmable
// wait states, byte-lane stores, aligned/extended loads and a one-cycle response pulse.
//
// state  | meaning
// IDLE   | ready for a request; req_ready high
// WAIT   | wait-state down-counter running
// ACCESS | RAM read/write with the captured request
// RESP   | rsp_valid pulse with captured rdata/err
module mem_responder #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_fetch,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  wait_cnt;
    logic        accept;

    logic        cap_write;
    logic        cap_fetch;
    logic        cap_unsigned;
    logic [1:0]  cap_size;
    logic [1:0]  cap_lane;
    logic [AW-1:0] cap_idx;
    logic [31:0] cap_wdata;

    logic [1:0]  size_eff;
    logic        addr_err;
    logic        is_store;
    logic        do_write;
    logic [3:0]  byte_en;
    logic [31:0] lane_wdata;
    logic [31:0] rd_word;
    logic [31:0] rd_shift;
    logic [31:0] load_data;

    logic [31:0] rdata_q;
    logic        err_q;

    logic [31:0] mem [DEPTH];

    // Address bits above the word index only alias; they never reach the RAM.
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:AW+2];

    assign accept = req_valid && req_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    state_nxt = (WAIT_CYCLES > 0) ? ST_WAIT : ST_ACCESS;
                end
            end
            ST_WAIT: begin
                if (wait_cnt == 4'd0) begin
                    state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: state_nxt = ST_RESP;
            ST_RESP:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            ST_IDLE: req_ready = 1'b1;
            ST_RESP: rsp_valid = 1'b1;
            default: begin
                req_ready = 1'b0;
                rsp_valid = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= 4'd0;
        end else if (state == ST_IDLE && accept) begin
            wait_cnt <= WAIT_LOAD;
        end else if (state == ST_WAIT && wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cap_write    <= 1'b0;
            cap_fetch    <= 1'b0;
            cap_unsigned <= 1'b0;
            cap_size     <= 2'b00;
            cap_lane     <= 2'b00;
            cap_idx      <= '0;
            cap_wdata    <= 32'd0;
        end else if (accept) begin
            cap_write    <= req_write;
            cap_fetch    <= req_fetch;
            cap_unsigned <= req_unsigned;
            cap_size     <= req_size;
            cap_lane     <= req_addr[1:0];
            cap_idx      <= req_addr[AW+1:2];
            cap_wdata    <= req_wdata;
        end
    end

    // A fetch is always a word read, even when req_write was also set.
    always_comb begin
        size_eff = cap_fetch ? 2'b10 : cap_size;
        is_store = cap_write && !cap_fetch;
        case (size_eff)
            2'b00:   addr_err = 1'b0;
            2'b01:   addr_err = cap_lane[0];
            2'b10:   addr_err = (cap_lane != 2'b00);
            default: addr_err = 1'b1;
        endcase
        do_write = is_store && !addr_err;
    end

    always_comb begin
        byte_en    = 4'b0000;
        lane_wdata = cap_wdata;
        case (size_eff)
            2'b00: begin
                byte_en    = 4'b0001 << cap_lane;
                lane_wdata = {4{cap_wdata[7:0]}};
            end
            2'b01: begin
                byte_en    = cap_lane[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{cap_wdata[15:0]}};
            end
            2'b10: begin
                byte_en    = 4'b1111;
                lane_wdata = cap_wdata;
            end
            default: begin
                byte_en    = 4'b0000;
                lane_wdata = cap_wdata;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (state == ST_ACCESS && do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[cap_idx][8*i +: 8] <= lane_wdata[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        rd_word  = mem[cap_idx];
        rd_shift = rd_word >> {cap_lane, 3'b000};
        case (size_eff)
            2'b00: begin
                load_data = cap_unsigned ? {24'd0, rd_shift[7:0]}
                                         : {{24{rd_shift[7]}}, rd_shift[7:0]};
            end
            2'b01: begin
                load_data = cap_unsigned ? {16'd0, rd_shift[15:0]}
                                         : {{16{rd_shift[15]}}, rd_shift[15:0]};
            end
            default: load_data = rd_word;
        endcase
    end

    // Response data is registered at the end of ACCESS and held until the next RESP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else if (state == ST_ACCESS) begin
            err_q   <= addr_err;
            rdata_q <= (addr_err || is_store) ? 32'd0 : load_data;
        end
    end

    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder: one DUT with two wait states,
// a second with none for the minimum-latency case.
module tb_mem_responder;

    logic        clk;
    logic        rst;

    logic        req_valid, req_ready, req_write, req_fetch, req_unsigned;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    logic        z_req_valid, z_req_ready, z_req_write, z_req_fetch, z_req_unsigned;
    logic [31:0] z_req_addr, z_req_wdata;
    logic [1:0]  z_req_size;
    logic        z_rsp_valid, z_rsp_err;
    logic [31:0] z_rsp_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    mem_responder #(.DEPTH(1024), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_fetch(req_fetch), .req_addr(req_addr), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    mem_responder #(.DEPTH(1024), .WAIT_CYCLES(0)) dut_zero (
        .clk(clk), .rst(rst),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_write(z_req_write),
        .req_fetch(z_req_fetch), .req_addr(z_req_addr), .req_size(z_req_size),
        .req_unsigned(z_req_unsigned), .req_wdata(z_req_wdata),
        .rsp_valid(z_rsp_valid), .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Latency = rising edges from acceptance to the edge at which a consumer samples rsp_valid=1.
    task automatic xact(input logic w, input logic f, input logic [31:0] a, input logic [1:0] sz,
                        input logic u, input logic [31:0] wd,
                        output logic [31:0] rd, output logic e, output int lat,
                        output logic busy_ok, output logic one_shot);
        int k;
        rd = 32'd0; e = 1'b0; lat = -1; busy_ok = 1'b1; one_shot = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_fetch = f; req_addr = a;
        req_size = sz; req_unsigned = u; req_wdata = wd;
        k = 0;
        while (!req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!req_ready) begin
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_write = ~w; req_fetch = 1'b0; req_addr = 32'hFFFF_FFFF;
        req_size = 2'b11; req_unsigned = ~u; req_wdata = 32'h5A5A_5A5A;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (req_ready) busy_ok = 1'b0;
            if (rsp_valid) begin
                lat = n + 1;
                rd  = rsp_rdata;
                e   = rsp_err;
                break;
            end
        end
        if (lat > 0) begin
            @(negedge clk);
            one_shot = !rsp_valid && req_ready;
        end
    endtask

    task automatic zxact(input logic w, input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output int lat);
        rd = 32'd0; lat = -1;
        @(negedge clk);
        z_req_valid = 1'b1; z_req_write = w; z_req_fetch = 1'b0; z_req_addr = a;
        z_req_size = 2'b10; z_req_unsigned = 1'b0; z_req_wdata = wd;
        if (!z_req_ready) begin
            z_req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        z_req_valid = 1'b0; z_req_addr = 32'hFFFF_FFFF; z_req_wdata = 32'd0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (z_rsp_valid) begin
                lat = n + 1;
                rd  = z_rsp_rdata;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #1;
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", rsp_valid); end
        n_checks++; if (rsp_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", rsp_rdata); end
        n_checks++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", rsp_err); end
        n_checks++; if (z_req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_zero_ready: got %b expected 1", z_req_ready); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_word();
        logic [31:0] rd; logic e, bz, os; int lat;
        xact(1'b1, 1'b0, 32'h10, 2'b10, 1'b0, 32'hDEAD_BEEF, rd, e, lat, bz, os);
        n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL word_store_latency: got %0d expected 4", lat); end
        n_checks++; if (rd !== 32'd0 || e !== 1'b0) begin n_fail++; $display("FAIL word_store_rsp: got %h/%b expected 0/0", rd, e); end
        n_checks++; if (bz !== 1'b1) begin n_fail++; $display("FAIL word_store_busy_ready: got %b expected 1", bz); end
        n_checks++; if (os !== 1'b1) begin n_fail++; $display("FAIL word_store_one_pulse: got %b expected 1", os); end
        xact(1'b0, 1'b0, 32'h10, 2'b10, 1'b0, 32'd0, rd, e, lat, bz, os);
        n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL word_load_latency: got %0d expected 4", lat); end
        n_checks++; if (rd !== 32'hDEAD_BEEF || e !== 1'b0) begin n_fail++; $display("FAIL word_load: got %h/%b expected deadbeef/0", rd, e); end
    endtask

    task automatic test_byte();
        logic [31:0] rd; logic e, bz, os; int lat;
        xact(1'b1, 1'b0, 32'h13, 2'b00, 1'b0, 32'h1234_5680, rd, e, lat, bz, os);
        xact(1'b0, 1'b0, 32'h13, 2'b00, 1'b0, 32'd0, rd, e, lat, bz, os);
        n_checks++; if (rd !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL byte_signed: got %h expected ffffff80", rd); end
        xact(1'b0, 1'b0, 32'h13, 2'b00, 1'b1, 32'd0, rd, e, lat, bz, os);
        n_checks++; if (rd !== 32'h0000_0080) begin n_fail++; $display("FAIL byte_unsigned: got %h expected 00000080", rd); end
        xact(1'b0, 1'b0, 32'h10, 2'b10, 1'b1, 32'd0, rd, e, lat, bz, os);
        n_checks++; if (rd !== 32'h80AD_BEEF) begin n_fail++; $display("FAIL byte_lane_word: got %h expected 80adbeef", rd); end
        xact(1'b0, 1'b0, 32'h11, 2'b00, 1'b1, 32'd0, rd, e, lat, bz, os);
        n_checks++; if (rd !== 32'h0000_00BE) begin n_fail++; $display("FAIL byte_lane1: got %h expected 000000be", rd); end
        xact(1'b0, 1'b0, 32'h12, 2'b00, 1'b0, 32'd0, rd, e, lat, bz, os);
        n_checks++; if (rd !== 32'hFFFF_FFAD) begin n_fail++; $display("FAIL byte_lane2_signed: got %h expected ffffffad", rd); end
    endtask

    task automatic test_half();
        logic [31:0] rd; logic e, bz, os; int lat;
        xact(1'b1, 1'b0, 32'h20, 2'b10, 1'b0, 32'hAAAA_5555, rd, e, lat, bz, os);
        xact(1'b1, 1'b0, 32'h22, 2'b01, 1'b0, 32'hFFFF_1234, rd, e, lat, bz, os);
        xact(1'b0, 1'b0, 32'h22, 2'b01, 1'b0, 32'd0, rd, e, lat, bz, os);
        n_checks++; if (rd !== 32'h0000_1234 || e !== 1'b0) begin n_fail++; $display("FAIL half_load: got %h/%b expected 00001234/0", rd, e); end
        xact(1'b0, 1'b0, 32'h21, 2'b01, 1'b0, 32'd0, rd, e, lat, bz, os);
        n_checks++; if (rd !== 32'd0 || e !== 1'b1) begin n_fail++; $display("FAIL half_misaligned_load: got %h/%b expected 0/1", rd, e); end
        xact(1'b1, 1'b0, 32'h21, 2'b01, 1'b0, 32'h0000_BEEF, rd, e, lat, bz, os);
        n_checks++; if (e !== 1'b1) begin n_fail++; $display("FAIL half_misaligned_store_err: got %b expected 1", e); end
        xact(1'b0, 1'b0, 32'h20, 2'b10, 1'b0, 32'd0, rd, e, lat, bz, os);
        n_checks++; if (rd !== 32'h1234_5555) begin n_fail++; $display("FAIL half_word_after: got %h expected 12345555", rd); end
        xact(1'b1, 1'b0, 32'h20, 2'b01, 1'b0, 32'h0000_8001, rd, e, lat, bz, os);
        xact(1'b0, 1'b0, 32'h20, 2'b01, 1'b0, 32'd0, rd, e, lat, bz, os);
        n_checks++; if (rd !== 32'hFFFF_8001) begin n_fail++; $display("FAIL half_signed_low: got %h expected ffff8001", rd); end
        xact(1'b0, 1'b0, 32'h20, 2'b01, 1'b1, 32'd0, rd, e, lat, bz, os);
        n_checks++; if (rd !== 32'h0000_8001) begin n_fail++; $display("FAIL half_unsigned_low: got %h expected 00008001", rd); end
    endtask

    task automatic test_align();
        logic [31:0] rd; logic e, bz, os; int lat;
        xact(1'b1, 1'b0, 32'h04, 2'b10, 1'b0, 32'h0000_0013, rd, e, lat, bz, os);
        xact(1'b1, 1'b0, 32'h06, 2'b10, 1'b0, 32'hFFFF_FFFF, rd, e, lat, bz, os);
        n_checks++; if (rd !== 32'd0 || e !== 1'b1) begin n_fail++; $display("FAIL word_misaligned_store: got %h/%b expected 0/1", rd, e); end
        xact(1'b1, 1'b1, 32'h04, 2'b00, 1'b0, 32'hFFFF_FFFF, rd, e, lat, bz, os);
        n_checks++; if (rd !== 32'h0000_0013 || e !== 1'b0) begin n_fail++; $display("FAIL fetch: got %h/%b expected 00000013/0", rd, e); end
        xact(1'b0, 1'b0, 32'h04, 2'b10, 1'b0, 32'd0, rd, e, lat, bz, os);
        n_checks++; if (rd !== 32'h0000_0013) begin n_fail++; $display("FAIL no_write_check: got %h expected 00000013", rd); end
        xact(1'b0, 1'b1, 32'h06, 2'b00, 1'b0, 32'd0, rd, e, lat, bz, os);
        n_checks++; if (rd !== 32'd0 || e !== 1'b1) begin n_fail++; $display("FAIL fetch_misaligned: got %h/%b expected 0/1", rd, e); end
        xact(1'b0, 1'b0, 32'h04, 2'b11, 1'b0, 32'd0, rd, e, lat, bz, os);
        n_checks++; if (rd !== 32'd0 || e !== 1'b1) begin n_fail++; $display("FAIL reserved_size: got %h/%b expected 0/1", rd, e); end
    endtask

    task automatic test_back_to_back();
        logic [4:0] ready_tr, valid_tr;
        logic [31:0] rd_a, rd_b;
        int lat_b;
        ready_tr = 5'd0; valid_tr = 5'd0; rd_a = 32'd0; rd_b = 32'd0; lat_b = -1;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_fetch = 1'b0; req_addr = 32'h10;
        req_size = 2'b10; req_unsigned = 1'b0; req_wdata = 32'd0;
        @(posedge clk);
        #1;
        req_addr = 32'h04;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            ready_tr[n] = req_ready;
            valid_tr[n] = rsp_valid;
            if (rsp_valid) rd_a = rsp_rdata;
        end
        n_checks++; if (ready_tr !== 5'b10000) begin n_fail++; $display("FAIL b2b_ready_trace: got %b expected 10000", ready_tr); end
        n_checks++; if (valid_tr !== 5'b01000) begin n_fail++; $display("FAIL b2b_valid_trace: got %b expected 01000", valid_tr); end
        n_checks++; if (rd_a !== 32'h80AD_BEEF) begin n_fail++; $display("FAIL b2b_first_data: got %h expected 80adbeef", rd_a); end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (rsp_valid) begin
                lat_b = n + 1;
                rd_b  = rsp_rdata;
                break;
            end
        end
        n_checks++; if (lat_b !== 4 || rd_b !== 32'h0000_0013) begin n_fail++; $display("FAIL b2b_second: got lat %0d data %h expected 4/00000013", lat_b, rd_b); end
    endtask

    task automatic test_zero_wait();
        logic [31:0] rd; int lat;
        zxact(1'b1, 32'h40, 32'h600D_CAFE, rd, lat);
        n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL zero_wait_store_latency: got %0d expected 2", lat); end
        zxact(1'b0, 32'h40, 32'd0, rd, lat);
        n_checks++; if (lat !== 2 || rd !== 32'h600D_CAFE) begin n_fail++; $display("FAIL zero_wait_load: got lat %0d data %h expected 2/600dcafe", lat, rd); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic e, bz, os; int lat; logic seen;
        seen = 1'b0;
        xact(1'b1, 1'b0, 32'h30, 2'b10, 1'b0, 32'h0102_0304, rd, e, lat, bz, os);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_fetch = 1'b0; req_addr = 32'h30;
        req_size = 2'b10; req_unsigned = 1'b0; req_wdata = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mid_outputs: got ready %b valid %b expected 1/0", req_ready, rsp_valid); end
        @(negedge clk);
        rst = 1'b1;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL reset_mid_no_rsp: got %b expected 0", seen); end
        xact(1'b0, 1'b0, 32'h30, 2'b10, 1'b0, 32'd0, rd, e, lat, bz, os);
        n_checks++; if (rd !== 32'h0102_0304) begin n_fail++; $display("FAIL reset_mid_unchanged: got %h expected 01020304", rd); end
    endtask

    task automatic test_alias();
        logic [31:0] rd; logic e, bz, os; int lat;
        xact(1'b1, 1'b0, 32'h1000, 2'b10, 1'b0, 32'hCAFE_F00D, rd, e, lat, bz, os);
        xact(1'b0, 1'b0, 32'h0, 2'b10, 1'b0, 32'd0, rd, e, lat, bz, os);
        n_checks++; if (rd !== 32'hCAFE_F00D || e !== 1'b0) begin n_fail++; $display("FAIL alias_wrap: got %h/%b expected cafef00d/0", rd, e); end
        xact(1'b0, 1'b0, 32'h10, 2'b10, 1'b0, 32'd0, rd, e, lat, bz, os);
        n_checks++; if (rd !== 32'h80AD_BEEF) begin n_fail++; $display("FAIL alias_other_word: got %h expected 80adbeef", rd); end
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_fetch = 1'b0; req_addr = 32'd0;
        req_size = 2'b00; req_unsigned = 1'b0; req_wdata = 32'd0;
        z_req_valid = 1'b0; z_req_write = 1'b0; z_req_fetch = 1'b0; z_req_addr = 32'd0;
        z_req_size = 2'b00; z_req_unsigned = 1'b0; z_req_wdata = 32'd0;
        #2 rst = 1'b0;
        #20;
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_align();
        test_back_to_back();
        test_zero_wait();
        test_reset_mid();
        test_alias();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
